// File: rtl/hs32_timer_pkg.sv
//------------------------------------------------------------------------------
// hs32_timer_pkg -- shared tick-source, counting-mode and output-mode codes. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package hs32_timer_pkg;

  localparam logic [2:0] CLK_STOP     = 3'd0;
  localparam logic [2:0] CLK_DIV1     = 3'd1;
  localparam logic [2:0] CLK_DIV8     = 3'd2;
  localparam logic [2:0] CLK_DIV64    = 3'd3;
  localparam logic [2:0] CLK_DIV256   = 3'd4;
  localparam logic [2:0] CLK_DIV1024  = 3'd5;
  localparam logic [2:0] CLK_EXT_RISE = 3'd6;
  localparam logic [2:0] CLK_EXT_FALL = 3'd7;

  localparam logic [1:0] MODE_NORMAL  = 2'd0;
  localparam logic [1:0] MODE_CTC     = 2'd1;
  localparam logic [1:0] MODE_PWM     = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;

  localparam logic [1:0] OUT_OFF      = 2'd0;
  localparam logic [1:0] OUT_TOGGLE   = 2'd1;
  localparam logic [1:0] OUT_PWM      = 2'd2;
  localparam logic [1:0] OUT_PWM_INV  = 2'd3;

  localparam int PRESCALE_BITS = 10;

  // Low prescaler bits that must all be ones for a divided tick.
  function automatic logic [PRESCALE_BITS-1:0] prescale_mask(input logic [2:0] src);
    case (src)
      CLK_DIV8:   return 10'h007;
      CLK_DIV64:  return 10'h03F;
      CLK_DIV256: return 10'h0FF;
      default:    return 10'h3FF;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/hs32_timer_prescaler.sv
//------------------------------------------------------------------------------
// hs32_timer_prescaler -- 10-bit free-running prescaler and tick source mux. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hs32_timer_prescaler
  import hs32_timer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [2:0] i_clk_source,
  input  logic       i_io_risen,
  input  logic       i_io_fallen,
  output logic       o_tick
);

  logic [PRESCALE_BITS-1:0] r_prescaler;
  logic [PRESCALE_BITS-1:0] w_mask;
  logic                     w_prescaled;

  assign w_prescaled = (i_clk_source >= CLK_DIV8) && (i_clk_source <= CLK_DIV1024);
  assign w_mask      = prescale_mask(i_clk_source);

  // Held at zero outside the divided sources so /8 first ticks on the 8th cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_prescaler <= '0;
    end else if (w_prescaled) begin
      r_prescaler <= r_prescaler + 10'd1;
    end else begin
      r_prescaler <= '0;
    end
  end

  always_comb begin
    o_tick = 1'b0;
    case (i_clk_source)
      CLK_STOP:     o_tick = 1'b0;
      CLK_DIV1:     o_tick = 1'b1;
      CLK_EXT_RISE: o_tick = i_io_risen;
      CLK_EXT_FALL: o_tick = i_io_fallen;
      default:      o_tick = ((r_prescaler & w_mask) == w_mask);
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hs32_timer_unit.sv
//------------------------------------------------------------------------------
// hs32_timer_unit -- HS32 up-counter timer with compare interrupt and pin drive. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hs32_timer_unit
  import hs32_timer_pkg::*;
#(
  parameter int TIMER_BITS = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [2:0]            i_clk_source,
  input  logic [1:0]            i_timer_mode,
  input  logic [1:0]            i_output_mode,
  input  logic [TIMER_BITS-1:0] i_match,
  output logic                  o_int_match,
  output logic                  o_io,
  output logic                  o_io_oe,
  input  logic                  i_io_risen,
  input  logic                  i_io_fallen
);

  logic                  w_tick;
  logic                  w_tick_eff;
  logic                  w_match_ev;
  logic                  w_clear;
  logic                  w_bottom_ev;
  logic [TIMER_BITS-1:0] w_count_next;
  logic                  w_io_next;
  logic [TIMER_BITS-1:0] r_count;
  logic                  r_done;
  logic                  r_int_match;
  logic                  r_io;

  hs32_timer_prescaler u_prescaler (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clk_source (i_clk_source),
    .i_io_risen   (i_io_risen),
    .i_io_fallen  (i_io_fallen),
    .o_tick       (w_tick)
  );

  assign w_tick_eff   = w_tick && !r_done;
  assign w_match_ev   = w_tick_eff && (r_count == i_match);
  assign w_clear      = w_match_ev && ((i_timer_mode == MODE_CTC) || (i_timer_mode == MODE_ONESHOT));
  assign w_count_next = w_clear ? '0 : r_count + TIMER_BITS'(1);
  assign w_bottom_ev  = w_tick_eff && (w_count_next == '0);

  // Match is tested last so it overrides a coincident bottom event.
  always_comb begin
    w_io_next = r_io;
    case (i_output_mode)
      OUT_TOGGLE: begin
        if (w_match_ev) w_io_next = !r_io;
      end
      OUT_PWM: begin
        if (w_bottom_ev) w_io_next = 1'b1;
        if (w_match_ev)  w_io_next = 1'b0;
      end
      OUT_PWM_INV: begin
        if (w_bottom_ev) w_io_next = 1'b0;
        if (w_match_ev)  w_io_next = 1'b1;
      end
      default: w_io_next = r_io;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count     <= '0;
      r_done      <= 1'b0;
      r_int_match <= 1'b0;
      r_io        <= 1'b0;
    end else begin
      r_int_match <= w_match_ev;
      r_io        <= w_io_next;
      if (w_tick_eff) begin
        r_count <= w_count_next;
      end
      if (i_clk_source == CLK_STOP) begin
        r_done <= 1'b0;
      end else if (w_match_ev && (i_timer_mode == MODE_ONESHOT)) begin
        r_done <= 1'b1;
      end
    end
  end

  assign o_int_match = r_int_match;
  assign o_io        = r_io;
  assign o_io_oe     = (i_output_mode != OUT_OFF);

endmodule

`default_nettype wire

// File: tb/tb_hs32_timer_unit.sv
//------------------------------------------------------------------------------
// tb_hs32_timer_unit -- directed bench for 4-, 16- and 32-bit timer instances. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_hs32_timer_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  cs;
  logic [1:0]  tm;
  logic [1:0]  om;
  logic        rise;
  logic        fall;
  logic [15:0] m16;
  logic [3:0]  m4;
  logic [31:0] m32;
  logic        int16, io16, oe16;
  logic        int4, io4, oe4;
  logic        int32, io32, oe32;

  int n_tests = 0;
  int n_fail  = 0;

  hs32_timer_unit #(.TIMER_BITS(16)) dut16 (
    .i_clk(clk), .i_reset(rst), .i_clk_source(cs), .i_timer_mode(tm),
    .i_output_mode(om), .i_match(m16), .o_int_match(int16), .o_io(io16),
    .o_io_oe(oe16), .i_io_risen(rise), .i_io_fallen(fall)
  );

  hs32_timer_unit #(.TIMER_BITS(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_clk_source(cs), .i_timer_mode(tm),
    .i_output_mode(om), .i_match(m4), .o_int_match(int4), .o_io(io4),
    .o_io_oe(oe4), .i_io_risen(rise), .i_io_fallen(fall)
  );

  hs32_timer_unit #(.TIMER_BITS(32)) dut32 (
    .i_clk(clk), .i_reset(rst), .i_clk_source(cs), .i_timer_mode(tm),
    .i_output_mode(om), .i_match(m32), .o_int_match(int32), .o_io(io32),
    .o_io_oe(oe32), .i_io_risen(rise), .i_io_fallen(fall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cs  = 3'd0;
    tm  = 2'd0;
    om  = 2'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic r, input logic f);
    rise = r;
    fall = f;
    step(1);
    rise = 1'b0;
    fall = 1'b0;
    step(1);
  endtask

  initial begin
    rst = 1'b1; cs = 3'd0; tm = 2'd0; om = 2'd0;
    rise = 1'b0; fall = 1'b0; m16 = '0; m4 = '0; m32 = '0;
    step(2);
    chk("rst_count", dut16.r_count, 0);
    chk("rst_int", int16, 0);
    chk("rst_io", io16, 0);
    chk("rst_oe", oe16, 0);
    rst = 1'b0;

    // Reset asserted between edges clears state without a clock.
    m16 = 16'd2; om = 2'd1; tm = 2'd0; cs = 3'd1;
    step(5);
    chk("mid_count5", dut16.r_count, 5);
    chk("mid_io", io16, 1);
    #2;
    rst = 1'b1;
    cs  = 3'd0;
    #1;
    chk("async_count", dut16.r_count, 0);
    chk("async_io", io16, 0);
    chk("async_int", int16, 0);
    chk("async_oe", oe16, 1);
    @(negedge clk);
    rst = 1'b0;

    // CTC at clk/1, match 3, toggle output
    m16 = 16'd3; tm = 2'd1; om = 2'd1; cs = 3'd1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk("ctc_count", dut16.r_count, 64'(k % 4));
      chk("ctc_int", int16, 64'(k % 4 == 0));
      chk("ctc_io", io16, 64'((k / 4) % 2));
    end
    chk("ctc_oe", oe16, 1);
    do_reset();

    // Prescale /8, normal mode, match 2
    m16 = 16'd2; tm = 2'd0; om = 2'd0; cs = 3'd2;
    step(7);
    chk("p8_count7", dut16.r_count, 0);
    step(1);
    chk("p8_count8", dut16.r_count, 1);
    step(15);
    chk("p8_count23", dut16.r_count, 2);
    chk("p8_int23", int16, 0);
    step(1);
    chk("p8_int24", int16, 1);
    chk("p8_count24", dut16.r_count, 3);
    step(1);
    chk("p8_int25", int16, 0);
    do_reset();

    // PWM on the 4-bit instance: match 4, period 16
    m4 = 4'd4; tm = 2'd2; om = 2'd2; cs = 3'd1;
    step(16);
    chk("pwm_wrap_count", dut4.r_count, 0);
    chk("pwm_io16", io4, 1);
    chk("pwm_oe", oe4, 1);
    step(4);
    chk("pwm_io20", io4, 1);
    step(1);
    chk("pwm_io21", io4, 0);
    step(10);
    chk("pwm_io31", io4, 0);
    step(1);
    chk("pwm_io32", io4, 1);
    om = 2'd3;
    step(16);
    chk("pwmi_io48", io4, 0);
    step(4);
    chk("pwmi_io52", io4, 0);
    step(1);
    chk("pwmi_io53", io4, 1);
    step(10);
    chk("pwmi_io63", io4, 1);
    step(1);
    chk("pwmi_io64", io4, 0);
    do_reset();

    // Match 0 in CTC: back-to-back pulses, match beats bottom
    m16 = 16'd0; tm = 2'd1; om = 2'd2; cs = 3'd1;
    step(2);
    chk("m0_int_a", int16, 1);
    chk("m0_io_pwm", io16, 0);
    chk("m0_count", dut16.r_count, 0);
    step(1);
    chk("m0_int_b", int16, 1);
    om = 2'd3;
    step(1);
    chk("m0_io_inv", io16, 1);
    chk("m0_int_c", int16, 1);
    do_reset();

    // External edges
    m16 = 16'hFFFF; tm = 2'd0; om = 2'd0; cs = 3'd6;
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    chk("ext_rise_count", dut16.r_count, 3);
    cs = 3'd7;
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    chk("ext_fall_count", dut16.r_count, 4);
    do_reset();

    // One-shot, then re-arm via stop
    m16 = 16'd2; tm = 2'd3; om = 2'd0; cs = 3'd1;
    step(2);
    chk("os_count2", dut16.r_count, 2);
    chk("os_int_pre", int16, 0);
    step(1);
    chk("os_int", int16, 1);
    chk("os_count0", dut16.r_count, 0);
    step(1);
    chk("os_int_off", int16, 0);
    step(5);
    chk("os_hold_count", dut16.r_count, 0);
    chk("os_hold_int", int16, 0);
    cs = 3'd0;
    step(1);
    cs = 3'd1;
    step(2);
    chk("os_rearm_count", dut16.r_count, 2);
    step(1);
    chk("os_rearm_int", int16, 1);
    do_reset();

    // 32-bit: match above 16 bits must not alias to a low count
    m32 = 32'h0001_0003; tm = 2'd0; om = 2'd1; cs = 3'd1;
    step(4);
    chk("w32_count", dut32.r_count, 4);
    chk("w32_int", int32, 0);
    chk("w32_io", io32, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
